// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch FSM state type and datapath constants.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INCREMENT = 32'd4;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/pc_reg_32.sv
// pc_reg_32: program counter with async reset, load and modulo-2^32 increment.
module pc_reg_32 import mips_pkg::*; #(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_value,
  input  logic              inc,
  output logic [WORD_W-1:0] pc
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) pc <= RESET_PC;
    else pc <= load ? load_value : inc ? pc + PC_INCREMENT : pc;
endmodule

// File: rtl/fetch_unit_32.sv
// fetch_unit_32: IDLE/FETCH/HOLD instruction fetch with redirect priority.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets instead of masking them.
module fetch_unit_32 import mips_pkg::*; #(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic [WORD_W-1:0] pc_plus4,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  output logic              err_misaligned
);
  fetch_state_t state;
  logic [WORD_W-1:0] pc, target;
  logic bad_target;
`ifdef FETCH_ALIGN_CHECK_EN
  assign target = redirect_target;
  assign bad_target = |redirect_target[1:0];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) err_misaligned <= 1'b0;
    else if (redirect_valid && bad_target) err_misaligned <= 1'b1;
`else
  assign target = redirect_target & ~32'd3;
  assign bad_target = 1'b0;
  assign err_misaligned = 1'b0;
`endif
  pc_reg_32 #(.RESET_PC(RESET_PC)) u_pc (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (redirect_valid && !bad_target),
    .load_value (target),
    .inc        (!redirect_valid && imem_req && imem_ready),
    .pc         (pc)
  );
  assign imem_addr = pc;
  assign pc_plus4 = instr_pc + PC_INCREMENT;
  // A redirect discards any in-flight or held word and restarts fetch.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else if (redirect_valid) begin
      state       <= FETCH;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
    end else case (state)
      IDLE: begin
        state    <= FETCH;
        imem_req <= 1'b1;
      end
      FETCH: if (imem_ready) begin
        state       <= HOLD;
        imem_req    <= 1'b0;
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= pc;
      end
      HOLD: if (instr_ready) begin
        state       <= FETCH;
        imem_req    <= 1'b1;
        instr_valid <= 1'b0;
      end
      default: begin
        state       <= IDLE;
        imem_req    <= 1'b0;
        instr_valid <= 1'b0;
      end
    endcase
endmodule

// File: tb/tb_fetch_unit_32.sv
// tb_fetch_unit_32: directed scenarios plus random traffic checked against a transaction-level model.
module tb_fetch_unit_32;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0;
  logic imem_req, instr_valid, err_misaligned;
  logic imem_ready = 1'b0, instr_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] imem_addr, instr, instr_pc, pc_plus4;
  logic [31:0] imem_rdata = '0, redirect_target = '0;
  int checks = 0, errors = 0;
  logic m_req, m_valid, m_boot, m_err;
  logic [31:0] m_pc, m_instr, m_ipc;
  always #5 clock = ~clock;
  fetch_unit_32 #(.RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .err_misaligned(err_misaligned)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset;
    m_req = 0; m_valid = 0; m_boot = 1; m_err = 0;
    m_pc = 32'h0; m_instr = 0; m_ipc = 0;
  endtask
  task automatic compare_all(input string tag);
    check({tag, ".req"}, 32'(imem_req), 32'(m_req));
    check({tag, ".addr"}, imem_addr, m_pc);
    check({tag, ".valid"}, 32'(instr_valid), 32'(m_valid));
    check({tag, ".err"}, 32'(err_misaligned), 32'(m_err));
    if (m_valid) begin
      check({tag, ".instr"}, instr, m_instr);
      check({tag, ".ipc"}, instr_pc, m_ipc);
      check({tag, ".plus4"}, pc_plus4, m_ipc + 32'd4);
    end
  endtask
  task automatic step(input string tag, input logic rv, input logic [31:0] rt,
                      input logic rdy, input logic [31:0] rd, input logic ir);
    redirect_valid = rv; redirect_target = rt;
    imem_ready = rdy; imem_rdata = rd; instr_ready = ir;
    @(posedge clock);
    if (rv) begin
      if (ALIGN && rt[1:0] != 2'b00) m_err = 1;
      else m_pc = {rt[31:2], 2'b00};
      m_req = 1; m_valid = 0; m_boot = 0;
    end else if (m_boot) begin
      m_boot = 0; m_req = 1;
    end else if (m_req && rdy) begin
      m_instr = rd; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_req = 0; m_valid = 1;
    end else if (m_valid && ir) begin
      m_valid = 0; m_req = 1;
    end
    #1 compare_all(tag);
  endtask
  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check({tag, ".rst_req"}, 32'(imem_req), 32'd0);
    check({tag, ".rst_valid"}, 32'(instr_valid), 32'd0);
    check({tag, ".rst_addr"}, imem_addr, 32'h0);
    check({tag, ".rst_instr"}, instr, 32'h0);
    check({tag, ".rst_ipc"}, instr_pc, 32'h0);
    check({tag, ".rst_err"}, 32'(err_misaligned), 32'd0);
    model_reset();
    #2 reset_n = 1'b1;
  endtask
  initial begin
    logic rv, rdy, ir;
    logic [31:0] rt;
    model_reset();
    #3;
    check("reset.req", 32'(imem_req), 32'd0);
    check("reset.valid", 32'(instr_valid), 32'd0);
    check("reset.addr", imem_addr, 32'h0);
    check("reset.instr", instr, 32'h0);
    check("reset.err", 32'(err_misaligned), 32'd0);
    #9 reset_n = 1'b1;
    step("idle", 0, 0, 1, 32'h1111_0000, 1);
    check("seq.addr0", imem_addr, 32'h0);
    step("acc0", 0, 0, 1, 32'h1111_0000, 1);
    check("seq.ipc0", instr_pc, 32'h0);
    step("fetch4", 0, 0, 1, 32'h1111_0004, 1);
    check("seq.addr4", imem_addr, 32'h4);
    step("acc4", 0, 0, 1, 32'h1111_0004, 1);
    check("seq.ipc4", instr_pc, 32'h4);
    step("fetch8", 0, 0, 1, 32'h1111_0008, 1);
    check("seq.addr8", imem_addr, 32'h8);
    step("acc8", 0, 0, 1, 32'h2008_0005, 0);
    check("seq.ipc8", instr_pc, 32'h8);
    for (int i = 0; i < 5; i++) begin
      step("bp", 0, 0, 1, $urandom, 0);
      check("bp.instr", instr, 32'h2008_0005);
      check("bp.req", 32'(imem_req), 32'd0);
      check("bp.plus4", pc_plus4, 32'hC);
    end
    step("rd_to8", 1, 32'h8, 0, 0, 1);
    check("rd.addr8", imem_addr, 32'h8);
    step("rd_acc", 1, 32'h100, 1, 32'hDEAD_BEEF, 0);
    check("rd.addr100", imem_addr, 32'h100);
    check("rd.novalid", 32'(instr_valid), 32'd0);
    step("acc100", 0, 0, 1, 32'h0BAD_F00D, 1);
    check("rd.word", instr, 32'h0BAD_F00D);
    step("wrap_rd", 1, 32'hFFFF_FFFC, 0, 0, 1);
    step("wrap_acc", 0, 0, 1, 32'h1234_5678, 0);
    check("wrap.ipc", instr_pc, 32'hFFFF_FFFC);
    check("wrap.plus4", pc_plus4, 32'h0);
    check("wrap.addr", imem_addr, 32'h0);
    step("mis_rd", 1, 32'h102, 0, 0, 0);
    check("mis.addr", imem_addr, ALIGN ? 32'h0 : 32'h100);
    check("mis.err", 32'(err_misaligned), 32'(ALIGN));
    step("mis_hold", 0, 0, 0, 0, 0);
    step("mis_hold2", 0, 0, 0, 0, 0);
    check("mis.sticky", 32'(err_misaligned), 32'(ALIGN));
    async_reset("midfetch");
    step("post_idle", 0, 0, 1, 32'hAAAA_5555, 1);
    check("post.addr", imem_addr, 32'h0);
    check("post.req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 7) == 0);
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) rt[31:8] = 24'hFFFFFF;
      rdy = $urandom_range(0, 1) == 1;
      ir = $urandom_range(0, 1) == 1;
      step("rand", rv, rt, rdy, $urandom, ir);
      if ($urandom_range(0, 199) == 0) async_reset("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit_32.md
FETCH_UNIT_32 -- requirements
Module: fetch_unit_32

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first instruction fetched after reset.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address; equals the current PC.
REQ-006 imem_ready  input  1  memory accepts the request; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr_valid  output  1  instr/instr_pc/pc_plus4 hold a valid instruction for the decoder.
REQ-009 instr_ready  input  1  decoder consumes the instruction this cycle.
REQ-010 instr  output  32  instruction word to the decoder.
REQ-011 instr_pc  output  32  address of instr.
REQ-012 pc_plus4  output  32  instr_pc+4, the jal link value written to r31.
REQ-013 redirect_valid  input  1  branch/jump taken this cycle.
REQ-014 redirect_target  input  32  new PC on redirect.
REQ-015 err_misaligned  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and HOLD.
REQ-017 IDLE (one cycle after reset release) SHALL go to FETCH; imem_req=0.
REQ-018 FETCH SHALL drive imem_req=1 and imem_addr=pc; on imem_req&&imem_ready it SHALL latch instr=imem_rdata and instr_pc=pc, set pc<=pc+4, and enter HOLD.
REQ-019 HOLD SHALL drive instr_valid=1 and imem_req=0; on instr_ready it SHALL return to FETCH; outputs stay stable while instr_ready=0.
REQ-020 Accept-to-instr_valid latency SHALL be exactly 1 cycle; peak throughput SHALL be one instruction per 2 cycles.
REQ-021 PC arithmetic SHALL be modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000 without an error.
REQ-022 Redirect SHALL have priority over all other events: pc<=redirect_target, next state FETCH, instr_valid=0 next cycle.
REQ-023 A redirect coinciding with an imem accept SHALL discard the returned word; pc SHALL take the target, not pc+4.
REQ-024 A redirect coinciding with instr_ready in HOLD SHALL count the held instruction as consumed, then fetch the target.
REQ-025 pc_plus4 SHALL equal instr_pc+4 combinationally, with the same wrap rule.

Reset
REQ-026 Asserting reset_n low at any time, including mid-handshake, SHALL immediately force: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, err_misaligned=0.
REQ-027 A pending imem accept interrupted by reset SHALL be dropped.

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN defined: a redirect with redirect_target[1:0]!=0 SHALL set err_misaligned=1 (sticky until reset), leave pc unchanged, and still discard the in-flight/held instruction.
REQ-029 FETCH_ALIGN_CHECK_EN undefined: redirect_target[1:0] SHALL be forced to 2'b00 and err_misaligned SHALL be tied to 0.

Structure
REQ-030 Shared package mips_pkg SHALL hold the FSM state enum, the constant PC_INCREMENT=4 and the 32-bit word width constant.
REQ-031 One sub-module, pc_reg_32 (PC register with async reset, load and increment), SHALL be instantiated; everything else stays flat.

Verification
REQ-032 Reset with RESET_PC=0, imem_ready=1, instr_ready=1: imem_addr sequence 0x0,0x4,0x8; instr_valid asserted every second cycle with instr_pc 0x0,0x4,0x8.
REQ-033 Backpressure: instr_ready=0 for 5 cycles in HOLD with instr=0x2008_0005: instr, instr_pc and pc_plus4 stay stable and imem_req=0 throughout.
REQ-034 Redirect to 0x100 in the same cycle as the imem accept at 0x8: the returned word is never presented and the next imem_addr is 0x100.
REQ-035 Wrap: redirect to 0xFFFF_FFFC, then accept: instr_pc=0xFFFF_FFFC, pc_plus4=0x0, next imem_addr=0x0.
REQ-036 With FETCH_ALIGN_CHECK_EN, redirect to 0x102: err_misaligned=1 and stays 1; pc is unchanged. Without the macro, the next imem_addr is 0x100.
REQ-037 reset_n pulsed low while in FETCH waiting on imem_ready=0: imem_req and instr_valid drop asynchronously; after release, the first imem_addr is RESET_PC.
